// File: rtl/dma_block_device.sv
// Block-transfer I/O device feeding the cycle-stealing DMA controller.
// Periodically fills a DEPTH-beat buffer with deterministic data, raises an
// interrupt, then serves registered offset-addressed beats until the DMA
// controller strobes completion.
module dma_block_device #(
    parameter int unsigned          WORD_SIZE     = 16,
    parameter int unsigned          BURST         = 4,
    parameter int unsigned          DEPTH         = 3,
    parameter int unsigned          OFFSET_W      = 2,
    parameter int unsigned          FIRE_INTERVAL = 2443,
    parameter int unsigned          INT_CYCLES    = 10,
    parameter int unsigned          NUM_XFERS     = 2,
    parameter logic [WORD_SIZE-1:0] SEED          = 16'h1000
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic [OFFSET_W-1:0]        offset,
    input  logic                       rd_en,
    input  logic                       xfer_done,
    output logic                       interrupt,
    output logic [BURST*WORD_SIZE-1:0] data,
    output logic                       data_valid,
    output logic                       overrun,
    output logic [7:0]                 xfer_count
);

    localparam int unsigned DW    = BURST * WORD_SIZE;
    localparam int unsigned CNT_W = $clog2(FIRE_INTERVAL);
    localparam int unsigned INT_W = (INT_CYCLES > 1) ? $clog2(INT_CYCLES) : 1;

    localparam logic [CNT_W-1:0]     FireLast   = CNT_W'(FIRE_INTERVAL - 1);
    localparam logic [INT_W-1:0]     IntLast    = INT_W'(INT_CYCLES - 1);
    localparam logic [OFFSET_W:0]    DepthLim   = (OFFSET_W + 1)'(DEPTH);
    localparam logic [WORD_SIZE-1:0] XferStride = WORD_SIZE'(DEPTH * BURST);

    typedef enum logic [1:0] {StIdle, StAssert, StServe, StDone} state_e;

    state_e               state_q, state_d;
    logic [CNT_W-1:0]     cnt_q;
    logic [INT_W-1:0]     icnt_q;
    logic [WORD_SIZE-1:0] xfer_idx_q;
    logic [7:0]           xfer_count_q;
    logic                 overrun_q;
    logic [DW-1:0]        buf_q [DEPTH];
    logic [DW-1:0]        fill  [DEPTH];
    logic [DW-1:0]        data_q;
    logic                 data_valid_q;

    logic                 fire;
    logic                 done_hit;
    logic                 last_xfer;
    logic [7:0]           xfer_count_inc;
    logic [WORD_SIZE-1:0] fill_base;

    // The interval counter is frozen in DONE, so no fire can occur there.
    assign fire           = (state_q != StDone) && (cnt_q == FireLast);
    assign done_hit       = xfer_done && ((state_q == StAssert) || (state_q == StServe));
    assign xfer_count_inc = (xfer_count_q == 8'hFF) ? 8'hFF : xfer_count_q + 8'd1;
    assign last_xfer      = (NUM_XFERS != 0) && ({24'd0, xfer_count_inc} == NUM_XFERS);

    // State register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state_q <= StIdle;
        else          state_q <= state_d;
    end

    // Next-state logic; completion takes priority over read/timeout exits
    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle:   if (fire) state_d = StAssert;
            StAssert: begin
                if (xfer_done)                         state_d = last_xfer ? StDone : StIdle;
                else if (rd_en || (icnt_q == IntLast)) state_d = StServe;
            end
            StServe:  if (xfer_done) state_d = last_xfer ? StDone : StIdle;
            StDone:   state_d = StDone;
            default:  state_d = StIdle;
        endcase
    end

    // Outputs
    always_comb begin
        interrupt  = (state_q == StAssert);
        data       = data_q;
        data_valid = data_valid_q;
        overrun    = overrun_q;
        xfer_count = xfer_count_q;
    end

    // Free-running fire interval counter
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)               cnt_q <= '0;
        else if (state_q != StDone) cnt_q <= fire ? '0 : cnt_q + CNT_W'(1);
    end

    // Cycles spent with interrupt high; cleared outside ASSERT
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)                  icnt_q <= '0;
        else if (state_q == StAssert)  icnt_q <= icnt_q + INT_W'(1);
        else                           icnt_q <= '0;
    end

    // Transfer bookkeeping and sticky overrun
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            xfer_count_q <= '0;
            xfer_idx_q   <= '0;
            overrun_q    <= 1'b0;
        end else begin
            if (done_hit) begin
                xfer_count_q <= xfer_count_inc;
                xfer_idx_q   <= xfer_idx_q + WORD_SIZE'(1);
            end
            // A fire coinciding with completion still counts as missed.
            if (fire && (state_q != StIdle)) overrun_q <= 1'b1;
        end
    end

    // Fill pattern for the current transfer index
    always_comb begin
        fill_base = SEED + xfer_idx_q * XferStride;
        for (int unsigned b = 0; b < DEPTH; b++) begin
            for (int unsigned w = 0; w < BURST; w++) begin
                fill[b][w*WORD_SIZE +: WORD_SIZE] = fill_base + WORD_SIZE'(b * BURST + w);
            end
        end
    end

    // Buffer load on a fire that starts a new transfer
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int unsigned b = 0; b < DEPTH; b++) buf_q[b] <= '0;
        end else if (fire && (state_q == StIdle)) begin
            for (int unsigned b = 0; b < DEPTH; b++) buf_q[b] <= fill[b];
        end
    end

    // Registered read port; out-of-range offsets return zero, invalid
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            data_q       <= '0;
            data_valid_q <= 1'b0;
        end else if (rd_en) begin
            if ({1'b0, offset} < DepthLim) begin
                data_q       <= buf_q[offset];
                data_valid_q <= 1'b1;
            end else begin
                data_q       <= '0;
                data_valid_q <= 1'b0;
            end
        end else begin
            data_valid_q <= 1'b0;
        end
    end

endmodule

// File: doc/dma_block_device.md
Name: dma_block_device

Overview:
- Synthesizable, clocked external I/O device feeding the cycle-stealing DMA controller.
- Periodically fills an internal block buffer, raises interrupt, and serves offset-addressed multi-word beats to the DMA engine.
- Transfer end is taken from the DMA controller's completion strobe.
- Generalises the fixed 3-entry, 4-word device: depth, burst width, fire interval, pulse length and transfer count are parameters.
- Adds registered reads, deterministic data, overrun detection and a transfer counter.

Parameters:
WORD_SIZE, 16, bits per word
BURST, 4, words per beat (data bus = BURST*WORD_SIZE)
DEPTH, 3, beats per transfer (valid offsets 0..DEPTH-1)
OFFSET_W, 2, offset width; must satisfy 2^OFFSET_W >= DEPTH
FIRE_INTERVAL, 2443, clock cycles between fire events (>= 2)
INT_CYCLES, 10, maximum interrupt high time in cycles (>= 1)
NUM_XFERS, 2, transfers before going quiescent; 0 = unlimited
SEED, 16'h1000, base value of generated data

Ports:
clk  input  1  system clock, rising edge
reset_n  input  1  asynchronous active-low reset
offset  input  OFFSET_W  beat index to read
rd_en  input  1  read request for offset
xfer_done  input  1  DMA completion strobe, one cycle
interrupt  output  1  data-ready request to CPU
data  output  BURST*WORD_SIZE  registered beat data
data_valid  output  1  data holds a valid beat this cycle
overrun  output  1  sticky: fire event missed while busy
xfer_count  output  8  completed transfers, saturating at 255

Behaviour:
- Reset: asynchronous on reset_n low. Outputs reset as follows:
  - interrupt=0, data=0, data_valid=0, overrun=0, xfer_count=0.
  - Interval counter=0, transfer index=0, buffer=0, state=IDLE.
  - Assertion mid-transfer aborts the transfer immediately; no partial count.
- Interval counter:
  - Counts every cycle in IDLE/ASSERT/SERVE; frozen in DONE.
  - At count==FIRE_INTERVAL-1 the next edge sets count to 0 and generates a fire event.
  - First fire therefore occurs on the FIRE_INTERVAL-th rising edge after reset release.
- Fire event in IDLE:
  - Load the buffer: word w of beat b = SEED + t*DEPTH*BURST + b*BURST + w, mod 2^WORD_SIZE, where t = transfer index.
  - Word 0 sits in data[WORD_SIZE-1:0].
  - Set interrupt=1; go to ASSERT.
- Fire event in ASSERT/SERVE: set overrun=1 (sticky until reset). The buffer is not reloaded and no interrupt is raised.
- State machine:
  - IDLE: wait for fire.
  - ASSERT: interrupt high. Go to SERVE, dropping interrupt, after INT_CYCLES cycles or on the first rd_en, whichever comes first.
  - SERVE: interrupt low; serve reads until xfer_done.
  - DONE: terminal; interrupt stays 0; reads are still served.
- xfer_done in ASSERT or SERVE ends the transfer:
  - interrupt=0, xfer_count+1, t+1.
  - Next state is DONE if NUM_XFERS!=0 and the new count == NUM_XFERS, else IDLE.
  - xfer_done in IDLE or DONE is ignored.
- Same-cycle xfer_done and fire: xfer_done is processed first. The fire is counted as an overrun and is not a new transfer.
- Reads (any state):
  - rd_en with offset<DEPTH: data=buffer[offset] and data_valid=1 on the next edge.
  - Latency is 1 cycle; back-to-back reads are allowed every cycle.
  - rd_en with offset>=DEPTH: data=0, data_valid=0.
  - No rd_en: data_valid=0 and data holds its last value.
- Reads in IDLE return the previous buffer contents (all zero before the first fire).

Test Plan:
Use FIRE_INTERVAL=20, INT_CYCLES=4, DEPTH=3, BURST=4, SEED=16'h1000, NUM_XFERS=2.
1. Reset release, no reads -> interrupt rises on edge 20, stays high exactly 4 cycles, falls on edge 24; xfer_count=0.
2. After first interrupt, rd_en offsets 0,1,2 back-to-back -> data 0x1003_1002_1001_1000, 0x1007_1006_1005_1004, 0x100B_100A_1009_1008 one cycle later each, data_valid high 3 cycles; interrupt drops after the first rd_en.
3. rd_en offset=3 -> data=0, data_valid=0. Then xfer_done -> xfer_count=1. Second fire beat 0 = 0x100F_100E_100D_100C.
4. No xfer_done before the second fire -> overrun=1, buffer unchanged, no interrupt. Then xfer_done -> xfer_count=1, state IDLE.
5. Complete two transfers -> DONE: no further interrupt over 100 cycles; xfer_count=2; reads still return the last buffer.
6. Drop reset_n mid-SERVE, asynchronously and between edges -> all outputs 0 immediately. After release, the first interrupt arrives 20 edges later with beat 0 = 0x1003_1002_1001_1000.
